// File: rtl/video_scale_pkg.sv
// rtl/video_scale_pkg.sv - shared widths, rounding constant and averaging helpers for video_half_scaler
package video_scale_pkg;

    // Rounding term added to a sum of four samples before the divide-by-four.
    localparam int ROUND_K = 2;

    function automatic int unsigned pair_w(input int unsigned ch_width);
        return ch_width + 1;
    endfunction

    function automatic int unsigned quad_w(input int unsigned ch_width);
        return ch_width + 2;
    endfunction

    function automatic logic [31:0] pair_sum(input logic [31:0] a, input logic [31:0] b);
        return a + b;
    endfunction

    // pair is the stored horizontal sum from the line above.
    function automatic logic [31:0] avg4_round(input logic [31:0] pair,
                                               input logic [31:0] prev,
                                               input logic [31:0] cur);
        return (pair + prev + cur + 32'(ROUND_K)) >> 2;
    endfunction

endpackage

// File: rtl/half_line_ram.sv
// rtl/half_line_ram.sv - simple dual-port single-clock RAM holding one line of horizontal pair sums
module half_line_ram #(
    parameter  int DEPTH = 960,
    parameter  int WIDTH = 27,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/video_half_scaler.sv
// rtl/video_half_scaler.sv - 2:1 video decimator / pass-through feeding the frame buffer write port
// HALF_SCALER_AVG_EN selects the 2x2 rounded box average; undefined gives nearest decimation.
module video_half_scaler
    import video_scale_pkg::*;
#(
    parameter int CH_WIDTH  = 8,
    parameter int CH_NUM    = 3,
    parameter int OUT_WIDTH = 32,
    parameter int H_ACTIVE  = 1920,
    parameter int V_ACTIVE  = 1080
) (
    input  logic                       I_clk,
    input  logic                       I_rstn,
    input  logic                       I_vs,
    input  logic                       I_de,
    input  logic [CH_NUM*CH_WIDTH-1:0] I_data,
    input  logic                       I_bypass,
    output logic                       O_FS,
    output logic                       O_wren,
    output logic [OUT_WIDTH-1:0]       O_data,
    output logic                       O_mode,
    output logic                       O_err
);

    localparam int PIX_W = CH_NUM * CH_WIDTH;
    localparam int XW    = $clog2(H_ACTIVE + 2);
    localparam int YW    = $clog2(V_ACTIVE + 1);

    logic             vs_q;
    logic             de_q;
    logic             active;
    logic             fs_d1;
    logic [XW-1:0]    x_cnt;
    logic [YW-1:0]    y_cnt;
    logic [PIX_W-1:0] prev_pix;
    logic             s1_valid;
    logic [PIX_W-1:0] s1_data;

    logic             vs_rise;
    logic             de_fall;
    logic [XW-1:0]    x_cur;
    logic [YW-1:0]    y_cur;
    logic             mode_cur;
    logic             tracking;
    logic             pix_ok;
    logic             x_odd;
    logic             y_odd;
    logic             s1_valid_next;
    logic [PIX_W-1:0] s1_data_next;

    // A pixel arriving on the sync edge itself already belongs to the new frame.
    assign vs_rise  = I_vs & ~vs_q;
    assign de_fall  = de_q & ~I_de;
    assign x_cur    = vs_rise ? '0 : x_cnt;
    assign y_cur    = vs_rise ? '0 : y_cnt;
    assign mode_cur = vs_rise ? I_bypass : O_mode;
    assign tracking = active | vs_rise;
    assign pix_ok   = tracking & I_de & (x_cur < XW'(H_ACTIVE)) & (y_cur < YW'(V_ACTIVE));
    assign x_odd    = x_cur[0];
    assign y_odd    = y_cur[0];

    always_ff @(posedge I_clk or negedge I_rstn) begin
        if (!I_rstn) begin
            vs_q   <= 1'b0;
            de_q   <= 1'b0;
            active <= 1'b0;
            fs_d1  <= 1'b0;
            O_FS   <= 1'b0;
            x_cnt  <= '0;
            y_cnt  <= '0;
            O_mode <= 1'b0;
            O_err  <= 1'b0;
        end else begin
            vs_q  <= I_vs;
            de_q  <= I_de;
            fs_d1 <= I_vs;
            O_FS  <= fs_d1;
            if (vs_rise) begin
                active <= 1'b1;
                O_mode <= I_bypass;
                x_cnt  <= I_de ? XW'(1) : '0;
                y_cnt  <= '0;
            end else if (active) begin
                if (de_fall) begin
                    if (x_cnt != XW'(H_ACTIVE)) begin
                        O_err <= 1'b1;
                    end
                    x_cnt <= '0;
                    if (y_cnt != YW'(V_ACTIVE)) begin
                        y_cnt <= y_cnt + YW'(1);
                    end
                // Saturate one past H_ACTIVE so over-long lines still read as wrong length.
                end else if (I_de && (x_cnt != XW'(H_ACTIVE + 1))) begin
                    x_cnt <= x_cnt + XW'(1);
                end
            end
        end
    end

`ifdef HALF_SCALER_AVG_EN
    localparam int SUM1_W = pair_w(CH_WIDTH);
    localparam int HALF   = H_ACTIVE / 2;
    localparam int AW     = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CH_NUM*SUM1_W-1:0] wr_sum;
    logic [CH_NUM*SUM1_W-1:0] rd_sum;
    logic [PIX_W-1:0]         avg_pix;
    logic [AW-1:0]            half_idx;
    logic                     ram_wr;
    logic                     ram_rd;

    assign half_idx = AW'(x_cur >> 1);
    assign ram_wr   = pix_ok & ~mode_cur & x_odd & ~y_odd;
    assign ram_rd   = pix_ok & ~mode_cur & ~x_odd & y_odd;

    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        assign wr_sum[c*SUM1_W +: SUM1_W] =
            SUM1_W'(pair_sum(32'(prev_pix[c*CH_WIDTH +: CH_WIDTH]),
                             32'(I_data[c*CH_WIDTH +: CH_WIDTH])));
        assign avg_pix[c*CH_WIDTH +: CH_WIDTH] =
            CH_WIDTH'(avg4_round(32'(rd_sum[c*SUM1_W +: SUM1_W]),
                                 32'(prev_pix[c*CH_WIDTH +: CH_WIDTH]),
                                 32'(I_data[c*CH_WIDTH +: CH_WIDTH])));
    end

    half_line_ram #(
        .DEPTH (HALF),
        .WIDTH (CH_NUM * SUM1_W)
    ) u_line_ram (
        .clk     (I_clk),
        .wr_en   (ram_wr),
        .wr_addr (half_idx),
        .wr_data (wr_sum),
        .rd_en   (ram_rd),
        .rd_addr (half_idx),
        .rd_data (rd_sum)
    );
`endif

    always_comb begin
        s1_valid_next = 1'b0;
        s1_data_next  = I_data;
        if (mode_cur) begin
            s1_valid_next = pix_ok;
        end else begin
`ifdef HALF_SCALER_AVG_EN
            s1_valid_next = pix_ok & x_odd & y_odd;
            s1_data_next  = avg_pix;
`else
            s1_valid_next = pix_ok & x_odd & ~y_odd;
            s1_data_next  = prev_pix;
`endif
        end
    end

    always_ff @(posedge I_clk or negedge I_rstn) begin
        if (!I_rstn) begin
            prev_pix <= '0;
            s1_valid <= 1'b0;
            s1_data  <= '0;
            O_wren   <= 1'b0;
            O_data   <= '0;
        end else begin
            if (pix_ok && !x_odd) begin
                prev_pix <= I_data;
            end
            s1_valid <= s1_valid_next;
            s1_data  <= s1_data_next;
            O_wren   <= s1_valid;
            O_data   <= OUT_WIDTH'(s1_data);
        end
    end

endmodule

// File: tb/tb_video_half_scaler.sv
// tb/tb_video_half_scaler.sv - scoreboard bench for video_half_scaler on a small 8x4 raster
module tb_video_half_scaler;

    localparam int CW = 8;
    localparam int CN = 3;
    localparam int OW = 32;
    localparam int H  = 8;
    localparam int V  = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          vs;
    logic          de;
    logic          byp;
    logic [23:0]   din;
    logic          fs;
    logic          wren;
    logic [OW-1:0] dout;
    logic          mode;
    logic          err;

    video_half_scaler #(
        .CH_WIDTH (CW),
        .CH_NUM   (CN),
        .OUT_WIDTH(OW),
        .H_ACTIVE (H),
        .V_ACTIVE (V)
    ) dut (
        .I_clk   (clk),
        .I_rstn  (rstn),
        .I_vs    (vs),
        .I_de    (de),
        .I_data  (din),
        .I_bypass(byp),
        .O_FS    (fs),
        .O_wren  (wren),
        .O_data  (dout),
        .O_mode  (mode),
        .O_err   (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] data;
        int          at;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [23:0] img [0:5][0:11];
    int          llen [0:5];
    logic [7:0]  r0 [8] = '{8'd1, 8'd2, 8'd0, 8'd0, 8'd0, 8'd1, 8'd255, 8'd255};
    logic [7:0]  r1 [8] = '{8'd3, 8'd4, 8'd0, 8'd1, 8'd1, 8'd1, 8'd255, 8'd255};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_fs"}, fs, 0);
        chk({tag, "_wren"}, wren, 0);
        chk({tag, "_data"}, dout, 0);
        chk({tag, "_mode"}, mode, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] box_avg(input int y, input int x);
        logic [23:0] r;
        int          s;
        for (int c = 0; c < CN; c++) begin
            s = int'(img[y-1][x-1][c*CW +: CW]) + int'(img[y-1][x][c*CW +: CW])
              + int'(img[y][x-1][c*CW +: CW]) + int'(img[y][x][c*CW +: CW]) + 2;
            r[c*CW +: CW] = 8'(s / 4);
        end
        return r;
    endfunction

    task automatic push(input logic [23:0] px);
        exp_t e;
        e.data = {8'h00, px};
        e.at   = cyc + 2;
        sb.push_back(e);
    endtask

    // Drives one frame (or vs-less lines); returns early with reset asserted at (ab_y, ab_x).
    task automatic send_frame(input bit b, input int nlines, input bit with_vs,
                              input bit toggle, input int ab_y, input int ab_x);
        if (with_vs) begin
            byp = b;
            de  = 1'b0;
            vs  = 1'b1;
            step(2);
            vs = 1'b0;
            step(2);
        end
        for (int y = 0; y < nlines; y++) begin
            for (int x = 0; x < llen[y]; x++) begin
                if (y == ab_y && x == ab_x) begin
                    rstn = 1'b0;
                    #1;
                    chk_zero("midrst");
                    sb.delete();
                    de = 1'b0;
                    return;
                end
                de  = 1'b1;
                din = img[y][x];
                if (toggle && x == 1) byp = ~byp;
                if (with_vs && x < H && y < V) begin
                    if (b) begin
                        push(img[y][x]);
                    end else if (x % 2 == 1) begin
`ifdef HALF_SCALER_AVG_EN
                        if (y % 2 == 1) push(box_avg(y, x));
`else
                        if (y % 2 == 0) push(img[y][x-1]);
`endif
                    end
                end
                step(1);
            end
            de  = 1'b0;
            din = 24'($urandom);
            step(3);
            if (with_vs) chk("mode_line", mode, b);
        end
        step(4);
        chk("drain", sb.size(), 0);
    endtask

    task automatic fill(input bit rnd, input logic [23:0] val);
        for (int y = 0; y < 6; y++) begin
            llen[y] = H;
            for (int x = 0; x < 12; x++) img[y][x] = rnd ? 24'($urandom) : val;
        end
    endtask

    logic vs_h1 = 1'b0;
    logic vs_h2 = 1'b0;
    int   since_rst = 0;

    always @(negedge clk) begin
        if (!rstn) since_rst = 0;
        else since_rst++;
        if (since_rst >= 3) chk("fs", fs, vs_h2);
        vs_h2 = vs_h1;
        vs_h1 = vs;
        if (wren) begin
            if (sb.size() == 0) begin
                chk("spurious_wren", wren, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wdata", dout, e.data);
                chk("wlat", cyc, e.at);
            end
        end
    end

    initial begin
        rstn = 1'b0;
        vs   = 1'b0;
        de   = 1'b0;
        byp  = 1'b0;
        din  = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            vs  = 1'($urandom);
            de  = 1'($urandom);
            byp = 1'($urandom);
            din = 24'($urandom);
            #1;
            chk_zero("rst");
        end
        vs  = 1'b0;
        de  = 1'b0;
        byp = 1'b0;
        step(1);
        rstn = 1'b1;
        step(2);

        // Traffic before the first sync must produce nothing.
        fill(1, '0);
        send_frame(1'b1, 4, 1'b0, 1'b1, -1, -1);

        fill(0, 24'h102030);
        send_frame(1'b0, 4, 1'b1, 1'b0, -1, -1);
        chk("err_clean1", err, 0);

        fill(1, '0);
        for (int x = 0; x < H; x++) begin
            img[0][x][7:0] = r0[x];
            img[1][x][7:0] = r1[x];
        end
        send_frame(1'b0, 4, 1'b1, 1'b0, -1, -1);
        chk("err_clean2", err, 0);

        fill(1, '0);
        llen[0] = H - 2;
        llen[1] = H - 2;
        send_frame(1'b0, 4, 1'b1, 1'b0, -1, -1);
        chk("err_short", err, 1);

        fill(1, '0);
        llen[1] = H + 2;
        send_frame(1'b1, 5, 1'b1, 1'b1, -1, -1);
        chk("mode_byp", mode, 1);
        chk("err_sticky1", err, 1);

        fill(1, '0);
        send_frame(1'b0, 4, 1'b1, 1'b0, -1, -1);
        chk("mode_back", mode, 0);
        chk("err_sticky2", err, 1);

        fill(1, '0);
        send_frame(1'b0, 4, 1'b1, 1'b0, 1, 3);
        step(3);
        chk_zero("held_rst");
        rstn = 1'b1;
        step(2);
        send_frame(1'b1, 2, 1'b0, 1'b0, -1, -1);
        chk("err_after_rst", err, 0);

        fill(1, '0);
        send_frame(1'b0, 4, 1'b1, 1'b0, -1, -1);
        chk("err_final", err, 0);
        chk("left_over", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/video_half_scaler.md
# video_half_scaler

Pixel-clock-domain pre-processing stage in the split-screen path, directly upstream of the write-only frame buffer controller. It takes one RGB video stream (vs/de/data) and produces one of two outputs. In scale mode, it emits a 2:1 horizontally and vertically decimated stream, so a full frame lands in one quadrant of the four-split canvas. In bypass mode, it passes the stream through unchanged for full-screen display. Its outputs connect straight to the frame buffer's user write interface: frame sync, write enable and 32-bit write data.

## Interface
- CH_WIDTH, 8, bits per colour channel
- CH_NUM, 3, channels per pixel (RGB)
- OUT_WIDTH, 32, output word width; must be ≥ CH_NUM*CH_WIDTH; upper bits zero-padded
- H_ACTIVE, 1920, expected active pixels per line; must be even
- V_ACTIVE, 1080, expected active lines per frame; must be even

Ports (clock and reset first):
- I_clk  in  1  pixel clock; the only clock
- I_rstn  in  1  reset, asynchronous, active-low
- I_vs  in  1  vertical sync, active-high; rising edge marks frame start
- I_de  in  1  active-pixel qualifier
- I_data  in  CH_NUM*CH_WIDTH  pixel data, channel 0 in LSBs
- I_bypass  in  1  1 = full-screen pass-through, 0 = half scale; sampled only at the I_vs rising edge
- O_FS  out  1  I_vs delayed 2 cycles; feeds the frame buffer's frame-sync input
- O_wren  out  1  output pixel valid
- O_data  out  OUT_WIDTH  {zero pad, pixel}
- O_mode  out  1  latched bypass mode for the current frame
- O_err  out  1  sticky line-length error

## Operation
- Idle after reset. Frame tracking starts only at the first I_vs rising edge. Until then, O_wren stays 0.
- At the I_vs rising edge:
  - x and y reset to 0.
  - O_mode <= I_bypass.
  - The line-buffer write pointer resets.
- x counts I_de cycles within a line. At the I_de falling edge:
  - If x != H_ACTIVE, set O_err.
  - y increments, saturating at V_ACTIVE.
- Pixels with x ≥ H_ACTIVE or y ≥ V_ACTIVE are discarded in both modes.
- Bypass mode: O_wren/O_data equal I_de/I_data delayed 2 cycles.
- Scale mode, even line (y[0]=0):
  - On even x, register the pixel.
  - On odd x, write the per-channel horizontal pair sum (CH_WIDTH+1 bits) into the line buffer at index x>>1.
  - No output.
- Scale mode, odd line:
  - On even x, register the pixel and issue a line-buffer read at index x>>1.
  - On odd x, compute per channel: (stored_sum + prev + cur + 2) >> 2. The sum is CH_WIDTH+2 bits wide and cannot overflow. This is round-half-up.
  - Emit one output word.
- Output count per frame in scale mode: (H_ACTIVE/2)*(V_ACTIVE/2). A line with an odd pixel count drops its trailing pixel.
- A change on I_bypass mid-frame is ignored until the next I_vs rising edge.
- O_err clears only on reset.
- Reset mid-frame:
  - All outputs go to 0 immediately.
  - Line-buffer contents are don't-care.
  - No O_wren until the next I_vs rising edge.

## Timing
- Reset values: O_FS=0, O_wren=0, O_data=0, O_mode=0, O_err=0.
- Bypass latency: 2 cycles, input pixel to O_wren.
- Scale latency: 2 cycles from the odd-x input pixel to O_wren.
- O_FS uses the same 2-cycle delay in both modes, so sync stays aligned with data.
- No backpressure. O_wren is at most one pulse per cycle. The downstream FIFO full flag is not observed.
- Line-buffer RAM: synchronous read, 1-cycle latency. Read and write never target the same line parity in one cycle.

## Configuration
- HALF_SCALER_AVG_EN defined:
  - 2×2 box average with rounding, as above.
  - Line buffer of H_ACTIVE/2 × CH_NUM*(CH_WIDTH+1) bits is instantiated.
- HALF_SCALER_AVG_EN undefined:
  - Nearest decimation. The output is the even-x pixel of each even line, emitted at the following odd-x cycle.
  - Odd lines produce nothing. No line buffer.
  - Latency, output count and bypass behaviour are unchanged.

## Structure
- Package video_scale_pkg:
  - Channel and sum widths (CH_WIDTH+1, CH_WIDTH+2).
  - Rounding constant 2.
  - A function for the per-channel pair sum and the 4-way rounded average.
- One sub-module, half_line_ram:
  - Simple dual-port, single-clock RAM.
  - Depth H_ACTIVE/2, registered read.
  - Only present with HALF_SCALER_AVG_EN.

## Test plan
- Reset with I_rstn=0 and random inputs -> all outputs 0. No O_wren before the first I_vs edge after release.
- H_ACTIVE=4, V_ACTIVE=4, scale mode, constant pixel 0x102030 -> exactly 4 O_wren pulses, each with O_data=0x00102030, 2 cycles after each odd-x pixel of lines 1 and 3.
- Rounding (AVG_EN), 2×2 blocks with channel 0 values:
  - {1,2,3,4} -> 3
  - {0,0,0,1} -> 0
  - {0,1,1,1} -> 1
  - {255,255,255,255} -> 255
- Full 1920×1080 with I_bypass=1 at I_vs -> 2073600 pulses, data equal to input delayed 2 cycles. Toggling I_bypass mid-frame leaves O_mode unchanged until the next I_vs.
- One 1918-pixel line -> O_err=1 and stays set through later frames. Scale output for that line pair is 959 words.
- Assert I_rstn=0 mid-frame -> outputs 0 within the same cycle. After release, no O_wren until a new I_vs rising edge, then correct output counts resume.
